sprite_fetch: RTL and testbench

Per-pixel read front-end for one animated sprite stored in a single-port sprite SRAM (e.g. the pod image RAM). It sits between the VGA scan generator and the sprite SRAM. From the current scan coordinate it computes the SRAM address, absorbs the SRAM's one-cycle read latency, and applies the chroma key. It delivers an aligned `pix_out`/`pix_hit` pair to the display mixer. It also owns the sprite's screen position (latched at frame boundaries) and its animation-frame counter.

---
 rtl/sprite_fetch_pkg.sv | 27 ++
 rtl/sprite_fetch_if.sv | 37 +++
 rtl/sprite_fetch_anim_ctrl.sv | 71 +++++++
 rtl/sprite_fetch.sv | 91 +++++++++
 tb/tb_sprite_fetch.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/sprite_fetch_pkg.sv
// sprite_fetch_pkg: scan geometry, default chroma key and span-test helper
// shared by the sprite fetch front-end, the mixer and other sprite blocks.
package sprite_fetch_pkg;

    localparam int VGA_X_W = 10;
    localparam int VGA_Y_W = 10;
    localparam int VGA_E_W = VGA_X_W + 1;
    localparam logic [11:0] KEY_COLOR_DEF = 12'h0F0;

    typedef struct packed {
        logic v;
        logic box;
    } pipe_t;

    // Span end is formed one bit wider so a sprite hanging off the right or
    // bottom edge is clipped rather than wrapped back to coordinate 0.
    function automatic logic span_hit(
        input logic [VGA_X_W-1:0] p,
        input logic [VGA_X_W-1:0] base,
        input int                 len
    );
        logic [VGA_E_W-1:0] end_v;
        end_v = {1'b0, base} + VGA_E_W'(len);
        return (p >= base) && ({1'b0, p} < end_v);
    endfunction

endpackage

// File: rtl/sprite_fetch_if.sv
// sprite_fetch_if: scan input, SRAM port and mixer output of one sprite fetch unit.
interface sprite_fetch_if
    import sprite_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 16
) ();

    logic [VGA_X_W-1:0]    pixel_x;
    logic [VGA_Y_W-1:0]    pixel_y;
    logic                  pixel_valid;
    logic                  frame_tick;
    logic                  anim_en;
    logic                  pos_load;
    logic [VGA_X_W-1:0]    pos_x;
    logic [VGA_Y_W-1:0]    pos_y;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic                  sram_en;
    logic                  sram_we;
    logic [DATA_WIDTH-1:0] sram_data;
    logic [DATA_WIDTH-1:0] pix_out;
    logic                  pix_hit;
    logic                  out_valid;

    modport slave (
        input  pixel_x, pixel_y, pixel_valid, frame_tick, anim_en,
        input  pos_load, pos_x, pos_y, sram_data,
        output sram_addr, sram_en, sram_we, pix_out, pix_hit, out_valid
    );

    modport master (
        output pixel_x, pixel_y, pixel_valid, frame_tick, anim_en,
        output pos_load, pos_x, pos_y, sram_data,
        input  sram_addr, sram_en, sram_we, pix_out, pix_hit, out_valid
    );

endinterface

// File: rtl/sprite_fetch_anim_ctrl.sv
// sprite_anim_ctrl: frame-boundary shadowed sprite position and animation
// frame counter (frame_idx advances every FRAME_DIV enabled frame ticks).
module sprite_anim_ctrl
    import sprite_fetch_pkg::*;
#(
    parameter int FRAMES    = 4,
    parameter int FRAME_DIV = 8,
    parameter int INIT_X    = 0,
    parameter int INIT_Y    = 0,
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
    localparam int TW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_frame_tick,
    input  logic               i_anim_en,
    input  logic               i_pos_load,
    input  logic [VGA_X_W-1:0] i_pos_x,
    input  logic [VGA_Y_W-1:0] i_pos_y,
    output logic [VGA_X_W-1:0] o_cur_x,
    output logic [VGA_Y_W-1:0] o_cur_y,
    output logic [FW-1:0]      o_frame_idx
);

    logic [VGA_X_W-1:0] r_cur_x, r_pend_x;
    logic [VGA_Y_W-1:0] r_cur_y, r_pend_y;
    logic               r_pend_v;
    logic [TW-1:0]      r_tick_cnt;
    logic [FW-1:0]      r_frame_idx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cur_x     <= VGA_X_W'(INIT_X);
            r_cur_y     <= VGA_Y_W'(INIT_Y);
            r_pend_x    <= '0;
            r_pend_y    <= '0;
            r_pend_v    <= 1'b0;
            r_tick_cnt  <= '0;
            r_frame_idx <= '0;
        end else begin
            // A load coinciding with the tick bypasses the shadow registers.
            if (i_frame_tick) begin
                if (i_pos_load) begin
                    r_cur_x <= i_pos_x;
                    r_cur_y <= i_pos_y;
                end else if (r_pend_v) begin
                    r_cur_x <= r_pend_x;
                    r_cur_y <= r_pend_y;
                end
                r_pend_v <= 1'b0;
            end else if (i_pos_load) begin
                r_pend_x <= i_pos_x;
                r_pend_y <= i_pos_y;
                r_pend_v <= 1'b1;
            end
            if (i_frame_tick && i_anim_en) begin
                if (r_tick_cnt == TW'(FRAME_DIV - 1)) begin
                    r_tick_cnt  <= '0;
                    r_frame_idx <= (r_frame_idx == FW'(FRAMES - 1)) ? '0 : r_frame_idx + 1'b1;
                end else begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end
            end
        end
    end

    assign o_cur_x     = r_cur_x;
    assign o_cur_y     = r_cur_y;
    assign o_frame_idx = r_frame_idx;

endmodule

// File: rtl/sprite_fetch.sv
// sprite_fetch: per-pixel sprite SRAM read front-end with hit box, address
// generation, 2-cycle aligned pipeline and chroma key.
module sprite_fetch
    import sprite_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 12,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    SPRITE_W   = 64,
    parameter int                    SPRITE_H   = 32,
    parameter int                    FRAMES     = 4,
    parameter int                    FRAME_DIV  = 8,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = DATA_WIDTH'(KEY_COLOR_DEF),
    parameter int                    INIT_X     = 0,
    parameter int                    INIT_Y     = 0
) (
    input logic           clk,
    input logic           reset_n,
    sprite_fetch_if.slave bus
);

    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    logic [VGA_X_W-1:0]    w_cur_x, w_dx;
    logic [VGA_Y_W-1:0]    w_cur_y, w_dy;
    logic [FW-1:0]         w_frame_idx;
    logic                  w_in_box, w_opaque;
    logic [ADDR_WIDTH-1:0] w_addr;

    logic [ADDR_WIDTH-1:0] r_sram_addr;
    logic                  r_sram_en;
    pipe_t                 r_s1, r_s2;
    logic [DATA_WIDTH-1:0] r_pix_out;
    logic                  r_pix_hit, r_out_valid;

    sprite_anim_ctrl #(
        .FRAMES    (FRAMES),
        .FRAME_DIV (FRAME_DIV),
        .INIT_X    (INIT_X),
        .INIT_Y    (INIT_Y)
    ) u_anim (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_frame_tick (bus.frame_tick),
        .i_anim_en    (bus.anim_en),
        .i_pos_load   (bus.pos_load),
        .i_pos_x      (bus.pos_x),
        .i_pos_y      (bus.pos_y),
        .o_cur_x      (w_cur_x),
        .o_cur_y      (w_cur_y),
        .o_frame_idx  (w_frame_idx)
    );

    assign w_in_box = bus.pixel_valid
                    & span_hit(bus.pixel_x, w_cur_x, SPRITE_W)
                    & span_hit(bus.pixel_y, w_cur_y, SPRITE_H);
    assign w_dx     = bus.pixel_x - w_cur_x;
    assign w_dy     = bus.pixel_y - w_cur_y;
    assign w_addr   = ADDR_WIDTH'(32'(w_frame_idx) * 32'(SPRITE_W * SPRITE_H)
                                + 32'(w_dy) * 32'(SPRITE_W) + 32'(w_dx));
    assign w_opaque = bus.sram_data != KEY_COLOR;

    // Stage 1 issues the read; the valid/box flags then ride alongside the
    // SRAM's own register so they meet the read data in stage 2.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sram_addr <= '0;
            r_sram_en   <= 1'b0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_pix_out   <= '0;
            r_pix_hit   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_in_box) r_sram_addr <= w_addr;
            r_sram_en   <= w_in_box;
            r_s1        <= '{v: bus.pixel_valid, box: w_in_box};
            r_s2        <= r_s1;
            r_pix_hit   <= r_s2.box & w_opaque;
            r_pix_out   <= (r_s2.box & w_opaque) ? bus.sram_data : '0;
            r_out_valid <= r_s2.v;
        end
    end

    assign bus.sram_addr = r_sram_addr;
    assign bus.sram_en   = r_sram_en;
    assign bus.sram_we   = 1'b0;
    assign bus.pix_out   = r_pix_out;
    assign bus.pix_hit   = r_pix_hit;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_sprite_fetch.sv
// tb_sprite_fetch: directed scan sequences against a reference model with an
// output scoreboard; the SRAM model returns addr[11:0] with an optional key at addr 5.
module tb_sprite_fetch;
    import sprite_fetch_pkg::*;

    typedef struct packed {
        logic        v;
        logic        h;
        logic [11:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sprite_fetch_if #(.DATA_WIDTH(12), .ADDR_WIDTH(16)) bus ();

    sprite_fetch #(
        .DATA_WIDTH (12),
        .ADDR_WIDTH (16),
        .SPRITE_W   (64),
        .SPRITE_H   (32),
        .FRAMES     (4),
        .FRAME_DIV  (8),
        .KEY_COLOR  (12'h0F0),
        .INIT_X     (0),
        .INIT_Y     (0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    bit key5 = 1'b0;
    always @(posedge clk)
        if (bus.sram_en) bus.sram_data <= (key5 && bus.sram_addr == 16'd5) ? 12'h0F0 : bus.sram_addr[11:0];

    int   n_assert = 0;
    int   n_fail = 0;
    exp_t q[$];
    int   m_cx, m_cy, m_px, m_py, m_f, m_tick, last_addr;
    bit   m_pv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int x, input int y, input bit v,
                        input bit ft = 1'b0, input bit ld = 1'b0,
                        input int lx = 0, input int ly = 0);
        exp_t e;
        bit   ib;
        int   a, d;
        bus.pixel_x     = 10'(x);
        bus.pixel_y     = 10'(y);
        bus.pixel_valid = v;
        bus.frame_tick  = ft;
        bus.pos_load    = ld;
        bus.pos_x       = 10'(lx);
        bus.pos_y       = 10'(ly);
        ib  = v && x >= m_cx && x < m_cx + 64 && y >= m_cy && y < m_cy + 32;
        a   = (m_f * 2048 + (y - m_cy) * 64 + (x - m_cx)) & 'hFFFF;
        d   = (key5 && a == 5) ? 'h0F0 : (a & 'hFFF);
        e.v = v;
        e.h = ib && d != 'h0F0;
        e.d = e.h ? 12'(d) : 12'h000;
        if (ib) last_addr = a;
        q.push_back(e);
        if (ft) begin
            if (ld) begin
                m_cx = lx;
                m_cy = ly;
            end else if (m_pv) begin
                m_cx = m_px;
                m_cy = m_py;
            end
            m_pv = 1'b0;
        end else if (ld) begin
            m_px = lx;
            m_py = ly;
            m_pv = 1'b1;
        end
        if (ft && bus.anim_en) begin
            if (m_tick == 7) begin
                m_tick = 0;
                m_f    = (m_f + 1) % 4;
            end else m_tick++;
        end
        @(posedge clk);
        #1;
        check("sram_en", bus.sram_en, ib);
        check("sram_addr", bus.sram_addr, last_addr);
        if (q.size() > 2) begin
            e = q.pop_front();
            check("out_valid", bus.out_valid, e.v);
            check("pix_hit", bus.pix_hit, e.h);
            check("pix_out", bus.pix_out, e.d);
        end
        bus.frame_tick = 1'b0;
        bus.pos_load   = 1'b0;
    endtask

    task automatic flush(input int n);
        repeat (n) step(0, 0, 1'b0);
    endtask

    task automatic do_reset();
        exp_t z;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_sram_addr", bus.sram_addr, 0);
        check("rst_sram_en", bus.sram_en, 0);
        check("rst_pix_out", bus.pix_out, 0);
        check("rst_pix_hit", bus.pix_hit, 0);
        check("rst_out_valid", bus.out_valid, 0);
        reset_n = 1'b1;
        m_cx = 0; m_cy = 0; m_px = 0; m_py = 0; m_pv = 1'b0;
        m_f = 0; m_tick = 0; last_addr = 0;
        z = '0;
        q.delete();
        q.push_back(z);
        q.push_back(z);
    endtask

    initial begin
        bus.pixel_x = '0; bus.pixel_y = '0; bus.pixel_valid = 1'b0;
        bus.frame_tick = 1'b0; bus.anim_en = 1'b0; bus.pos_load = 1'b0;
        bus.pos_x = '0; bus.pos_y = '0; bus.sram_data = '0;
        @(posedge clk);
        do_reset();
        check("sram_we", bus.sram_we, 0);

        // basic fetch at (100,50), including both neighbouring misses
        step(0, 0, 1'b0, 1'b1, 1'b1, 100, 50);
        for (int x = 99; x <= 164; x++) step(x, 50, 1'b1);
        step(100, 49, 1'b1);
        step(100, 82, 1'b1);
        flush(3);

        // chroma key at address 5
        key5 = 1'b1;
        step(105, 50, 1'b1);
        step(106, 50, 1'b1);
        flush(3);
        key5 = 1'b0;

        // animation: 8 ticks -> frame 1, 32 ticks -> frame 0, disabled holds
        bus.anim_en = 1'b1;
        for (int i = 0; i < 8; i++) step(0, 0, 1'b0, 1'b1);
        step(100, 50, 1'b1);
        check("anim_addr_f1", bus.sram_addr, 2048);
        for (int i = 0; i < 24; i++) step(0, 0, 1'b0, 1'b1);
        step(100, 50, 1'b1);
        check("anim_addr_wrap", bus.sram_addr, 0);
        bus.anim_en = 1'b0;
        for (int i = 0; i < 8; i++) step(0, 0, 1'b0, 1'b1);
        step(101, 51, 1'b1);
        check("anim_hold", bus.sram_addr, 65);
        flush(3);

        // shadowed position: applies only at the next frame tick
        step(0, 0, 1'b0, 1'b0, 1'b1, 200, 60);
        step(100, 50, 1'b1);
        step(200, 60, 1'b1);
        step(0, 0, 1'b0, 1'b1);
        step(200, 60, 1'b1);
        step(100, 50, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1, 300, 100);
        step(300, 100, 1'b1);
        step(0, 0, 1'b0, 1'b0, 1'b1, 10, 10);
        step(0, 0, 1'b0, 1'b0, 1'b1, 20, 20);
        step(0, 0, 1'b0, 1'b1);
        step(20, 20, 1'b1);
        step(10, 10, 1'b1);
        flush(3);

        // clipping at the right/bottom edge, no wrap to column 0
        step(0, 0, 1'b0, 1'b1, 1'b1, 1000, 470);
        for (int x = 1000; x <= 1023; x++) step(x, 470, 1'b1);
        step(0, 470, 1'b1);
        step(1010, 479, 1'b1);
        step(1010, 0, 1'b1);
        flush(3);

        // mid-stream reset with a non-zero frame and moved position
        step(0, 0, 1'b0, 1'b1, 1'b1, 100, 50);
        bus.anim_en = 1'b1;
        for (int i = 0; i < 8; i++) step(0, 0, 1'b0, 1'b1);
        bus.anim_en = 1'b0;
        for (int x = 100; x < 106; x++) step(x, 50, 1'b1);
        bus.pixel_x = 10'd106;
        bus.pixel_y = 10'd50;
        bus.pixel_valid = 1'b1;
        do_reset();
        step(0, 0, 1'b1);
        check("post_rst_addr", bus.sram_addr, 0);
        step(3, 2, 1'b1);
        step(100, 50, 1'b1);
        flush(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
